// File: rtl/uart_pkg.sv
// Shared UART constants and types for the RX and TX buffering blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

   localparam int UART_WIDTH         = 8;
   localparam int RX_FIFO_DEPTH_LOG2 = 4;
   localparam int TX_FIFO_DEPTH_LOG2 = 4;

   typedef logic [UART_WIDTH-1:0] uart_char_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Bundle of the UART-side handshake and CPU-side read/status signals of the RX buffer.
// Latency: n/a (wiring only).
// Backpressure: n/a; "slave" is the buffer's view, "master" is the UART + CPU environment.
// Signals: uart_full/uart_dout/uart_rd (UART handshake), rd_en/rd_data (FWFT pop),
//          empty/fifo_full/level/overflow (status), clr_ovf/flush (control).
interface uart_rx_fifo_if
   import uart_pkg::*;
#(
   parameter int DEPTH_LOG2 = RX_FIFO_DEPTH_LOG2,
   parameter int WIDTH      = UART_WIDTH
);

   logic                  uart_full;
   logic [WIDTH-1:0]      uart_dout;
   logic                  uart_rd;
   logic                  rd_en;
   logic [WIDTH-1:0]      rd_data;
   logic                  empty;
   logic                  fifo_full;
   logic [DEPTH_LOG2:0]   level;
   logic                  overflow;
   logic                  clr_ovf;
   logic                  flush;

   modport master (
      output uart_full, uart_dout, rd_en, clr_ovf, flush,
      input  uart_rd, rd_data, empty, fifo_full, level, overflow
   );

   modport slave (
      input  uart_full, uart_dout, rd_en, clr_ovf, flush,
      output uart_rd, rd_data, empty, fifo_full, level, overflow
   );

endinterface

// File: rtl/sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO with flush, level, empty and full.
// Latency: a push is visible at pop_dat/empty the cycle after the push edge.
// Backpressure: a push while full is accepted only if a pop frees a slot that cycle, else it is refused (drop).
// Ports: clk, rst (sync, active-high); push/push_dat; pop/pop_dat; flush;
//        empty, full, level (registered); drop (combinational, push refused this cycle).
module sync_fifo #(
   parameter int DEPTH_LOG2 = 4,
   parameter int WIDTH      = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push,
   input  logic [WIDTH-1:0]    push_dat,
   input  logic                pop,
   input  logic                flush,
   output logic [WIDTH-1:0]    pop_dat,
   output logic                empty,
   output logic                full,
   output logic [DEPTH_LOG2:0] level,
   output logic                drop
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef logic [DEPTH_LOG2-1:0] ptr_t;
   typedef logic [DEPTH_LOG2:0]   lvl_t;

   localparam ptr_t PTR_ONE = ptr_t'(1);
   localparam lvl_t LVL_ONE = lvl_t'(1);
   localparam lvl_t LVL_MAX = lvl_t'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   ptr_t             wptr;
   ptr_t             rptr;
   logic             pop_ok;
   logic             push_ok;
   lvl_t             lvl_nxt;

   // A pop while full frees the slot the same-cycle push lands in.
   always_comb begin
      pop_ok  = pop & ~empty;
      push_ok = push & (~full | pop_ok);
      drop    = push & ~flush & ~push_ok;
      lvl_nxt = level;
      case ({push_ok, pop_ok})
         2'b10:   lvl_nxt = level + LVL_ONE;
         2'b01:   lvl_nxt = level - LVL_ONE;
         default: lvl_nxt = level;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
         empty <= 1'b1;
         full  <= 1'b0;
      end else begin
         if (push_ok) wptr <= wptr + PTR_ONE;
         if (pop_ok)  rptr <= rptr + PTR_ONE;
         level <= lvl_nxt;
         empty <= (lvl_nxt == '0);
         full  <= (lvl_nxt == LVL_MAX);
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (push_ok && !flush) mem[wptr] <= push_dat;
   end

   assign pop_dat = mem[rptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Drains the UART receiver into a FWFT FIFO for the CPU, with sticky overflow reporting.
// Latency: byte captured at edge N is poppable (empty=0) after edge N; uart_rd pulses after edge N.
// Backpressure: none toward the UART (always drained); a byte arriving while full is dropped and flagged.
// Ports: clk, rst (sync, active-high); bus (uart_rx_fifo_if.slave) carrying the UART
//        handshake, the CPU pop port, status and the flush/clr_ovf controls.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH_LOG2 = RX_FIFO_DEPTH_LOG2,
   parameter int WIDTH      = UART_WIDTH
) (
   input  logic           clk,
   input  logic           rst,
   uart_rx_fifo_if.slave  bus
);

   logic cap;
   logic drop;

   // The UART keeps full high for one cycle after our read strobe, so the
   // strobe itself masks that cycle and prevents a double capture.
   assign cap = bus.uart_full & ~bus.uart_rd;

   sync_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .WIDTH      (WIDTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (cap),
      .push_dat (bus.uart_dout),
      .pop      (bus.rd_en),
      .flush    (bus.flush),
      .pop_dat  (bus.rd_data),
      .empty    (bus.empty),
      .full     (bus.fifo_full),
      .level    (bus.level),
      .drop     (drop)
   );

   // uart_rd pulses for every capture, including dropped or flushed bytes.
   // An overflow in the same cycle as clr_ovf keeps the flag set.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.uart_rd  <= 1'b0;
         bus.overflow <= 1'b0;
      end else begin
         bus.uart_rd <= cap;
         if (drop)             bus.overflow <= 1'b1;
         else if (bus.clr_ovf) bus.overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised and directed bench for uart_rx_fifo with a queue-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx_fifo;

   localparam int DEPTH = 16;

   logic clk;
   logic rst;

   uart_rx_fifo_if bus ();

   uart_rx_fifo dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: FIFO contents as a plain queue.
   logic [7:0] model_q [$];
   logic       m_ovf  = 1'b0;
   logic       m_rd   = 1'b0;
   logic       mon_on = 1'b0;

   // UART behavioural driver state.
   logic [7:0] pending [$];
   int         uphase  = 0;
   logic       cap_exp = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model update: applies the buffer's rules to the inputs seen at each edge.
   always @(posedge clk) begin
      if (rst) begin
         model_q.delete();
         m_ovf  = 1'b0;
         m_rd   = 1'b0;
         mon_on = 1'b1;
      end else begin
         logic popped;
         logic accept;
         m_rd = cap_exp;
         if (bus.flush) begin
            model_q.delete();
            if (bus.clr_ovf) m_ovf = 1'b0;
         end else begin
            popped = bus.rd_en && (model_q.size() > 0);
            accept = cap_exp && ((model_q.size() < DEPTH) || popped);
            if (popped) void'(model_q.pop_front());
            if (accept) model_q.push_back(bus.uart_dout);
            if (cap_exp && !accept) m_ovf = 1'b1;
            else if (bus.clr_ovf)   m_ovf = 1'b0;
         end
      end
   end

   // Monitor: compares DUT outputs against the model away from the active edge.
   always @(negedge clk) begin
      if (mon_on) begin
         check("uart_rd",   32'(bus.uart_rd),   32'(m_rd));
         check("level",     32'(bus.level),     32'(model_q.size()));
         check("empty",     32'(bus.empty),     32'(model_q.size() == 0));
         check("fifo_full", 32'(bus.fifo_full), 32'(model_q.size() == DEPTH));
         check("overflow",  32'(bus.overflow),  32'(m_ovf));
         if (model_q.size() > 0)
            check("head", 32'(bus.rd_data), 32'(model_q[0]));
         if (bus.rd_en && !bus.empty) begin
            if (model_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL pop_data: got %0h expected no data at %0t", bus.rd_data, $time);
            end else begin
               check("pop_data", 32'(bus.rd_data), 32'(model_q[0]));
            end
         end
      end
   end

   // One cycle of stimulus; called #1 after a rising edge, returns #1 after the next.
   task automatic step(input logic rd, input logic fl, input logic co, input logic r);
      bus.rd_en   = rd;
      bus.flush   = fl;
      bus.clr_ovf = co;
      rst         = r;
      case (uphase)
         0: begin
            if (pending.size() > 0) begin
               bus.uart_full = 1'b1;
               bus.uart_dout = pending.pop_front();
               cap_exp       = 1'b1;
               uphase        = 1;
            end
         end
         1: begin
            cap_exp = 1'b0;
            uphase  = 2;
         end
         default: begin
            bus.uart_full = 1'b0;
            uphase        = 0;
         end
      endcase
      @(posedge clk);
      #1;
   endtask

   // One UART byte: capture edge, strobe cycle, release cycle.
   task automatic send(input logic [7:0] b, input logic rd_cap, input logic fl_cap, input logic rst_mid);
      pending.push_back(b);
      step(rd_cap, fl_cap, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, rst_mid);
      step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pops(input int n);
      for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic fill16();
      for (int k = 0; k < DEPTH; k++) send(8'(k), 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst           = 1'b1;
      bus.uart_full = 1'b0;
      bus.uart_dout = '0;
      bus.rd_en     = 1'b0;
      bus.clr_ovf   = 1'b0;
      bus.flush     = 1'b0;
      @(posedge clk);
      #1;
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0);

      // Single byte, then pop it.
      send(8'hA5, 1'b0, 1'b0, 1'b0);
      pops(1);
      step(1'b0, 1'b0, 1'b0, 1'b0);

      // Fill with 0x00..0x0F (pointers wrap), then drain in order.
      fill16();
      pops(DEPTH);
      pops(1);

      // Overflow while full, then clear it.
      fill16();
      send(8'h77, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);

      // Full plus same-cycle pop: 0x55 accepted, no overflow.
      send(8'h55, 1'b1, 1'b0, 1'b0);
      pops(DEPTH);

      // Empty plus same-cycle pop: pop ignored, 0x3C lands.
      send(8'h3C, 1'b1, 1'b0, 1'b0);
      pops(1);

      // Flush during a capture, then reset mid-handshake.
      for (int k = 0; k < 5; k++) send(8'(8'hC0 + k), 1'b0, 1'b0, 1'b0);
      send(8'h99, 1'b0, 1'b1, 1'b0);
      send(8'h42, 1'b0, 1'b0, 1'b0);
      send(8'h43, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0);

      // Random traffic alternating fill-biased and drain-biased phases.
      for (int i = 0; i < 3000; i++) begin
         int rp;
         rp = (((i / 200) % 2) == 0) ? 15 : 70;
         if (uphase == 0 && pending.size() == 0 && $urandom_range(99) < 70)
            pending.push_back(8'($urandom));
         step(logic'($urandom_range(99) < rp),
              logic'($urandom_range(199) == 0),
              logic'($urandom_range(19) == 0),
              1'b0);
      end
      while (uphase != 0 || pending.size() != 0) step(1'b0, 1'b0, 1'b0, 1'b0);
      pops(DEPTH + 2);
      step(1'b0, 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
